// File: rtl/level_sequencer_pkg.sv
// Shared definitions for the word-typing level sequencer: state encoding,
// key codes, target word table and key normalisation helpers.
package level_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_CHECK = 3'd2,
    S_WON   = 3'd3,
    S_LOST  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [7:0] KEY_ENTER     = 8'h0D;
  localparam logic [7:0] KEY_BACKSPACE = 8'h08;
  localparam logic [7:0] ASCII_SPACE   = 8'h20;

  localparam logic [39:0] WORD_0 = "LOGIC";
  localparam logic [39:0] WORD_1 = "CLOCK";
  localparam logic [39:0] WORD_2 = "ADDER";

  // Levels beyond the table reuse it cyclically; positions past the word read as 0.
  function automatic logic [7:0] target_char(input logic [2:0] lvl, input int pos);
    logic [39:0] w;
    case (lvl)
      3'd1, 3'd4, 3'd7: w = WORD_1;
      3'd2, 3'd5:       w = WORD_2;
      default:          w = WORD_0;
    endcase
    w = w << (pos * 8);
    return w[39:32];
  endfunction

  function automatic logic [7:0] to_upper(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
  endfunction

  function automatic logic is_letter(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5A);
  endfunction

endpackage

// File: rtl/level_sequencer_if.sv
// Keyboard-in / display-out bundle between the key decoder, the level
// sequencer and the level display.
interface level_sequencer_if #(parameter int WORD_LEN = 5);
  logic                key_valid;
  logic [7:0]          key_ascii;
  logic [7:0]          counter;
  logic [7:0]          letter;
  logic [WORD_LEN-1:0] correct_mask;
  logic [WORD_LEN-1:0] wrong_mask;
  logic [2:0]          level;
  logic [2:0]          state_out;
  logic                lvl_won;
  logic                lvl_lost;
  logic                game_done;

  modport master (
    output key_valid, key_ascii,
    input  counter, letter, correct_mask, wrong_mask, level, state_out,
           lvl_won, lvl_lost, game_done
  );

  modport slave (
    input  key_valid, key_ascii,
    output counter, letter, correct_mask, wrong_mask, level, state_out,
           lvl_won, lvl_lost, game_done
  );
endinterface

// File: rtl/level_sequencer_hold_timer.sv
// Loadable saturating down-counter; expired is high once the loaded
// hold has run out and stays high until the next start.
module hold_timer #(
  parameter int HOLD = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic clear,
  output logic expired
);
  localparam int W = (HOLD > 1) ? $clog2(HOLD) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  // Loading HOLD-1 makes expired rise on the HOLD-th cycle after start.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (start)
      cnt_d = W'(HOLD - 1);
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == '0);
endmodule

// File: rtl/level_sequencer.sv
// Game-flow controller for the typing levels. Optional backspace editing
// in PLAY is enabled by defining LEVEL_SEQ_BACKSPACE_EN.
module level_sequencer
  import level_pkg::*;
#(
  parameter int NUM_LEVELS = 3,
  parameter int WORD_LEN   = 5,
  parameter int WIN_HOLD   = 100_000_000
) (
  input  logic             clk,
  input  logic             reset,
  level_sequencer_if.slave bus
);
  state_t              state_q, state_d;
  logic [7:0]          counter_q, counter_d;
  logic [7:0]          letter_q, letter_d;
  logic [WORD_LEN-1:0] correct_q, correct_d;
  logic [WORD_LEN-1:0] wrong_q, wrong_d;
  logic [2:0]          level_q, level_d;
  logic                won_q, won_d, lost_q, lost_d, done_q, done_d;
  logic                timer_start, timer_clear, timer_expired;
  logic [7:0]          key_up;
  logic                key_letter, key_enter;

  assign key_up     = to_upper(bus.key_ascii);
  assign key_letter = is_letter(key_up);
  assign key_enter  = bus.key_valid && (bus.key_ascii == KEY_ENTER);

  hold_timer #(.HOLD(WIN_HOLD)) u_hold (
    .clk     (clk),
    .reset   (reset),
    .start   (timer_start),
    .clear   (timer_clear),
    .expired (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    letter_d    = letter_q;
    correct_d   = correct_q;
    wrong_d     = wrong_q;
    level_d     = level_q;
    timer_start = 1'b0;
    timer_clear = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (key_enter) begin
          state_d     = S_PLAY;
          counter_d   = '0;
          correct_d   = '0;
          wrong_d     = '0;
          timer_clear = 1'b1;
        end
      end
      S_PLAY: begin
        if (bus.key_valid) begin
          if (key_letter) begin
            for (int i = 0; i < WORD_LEN; i++) begin
              if (counter_q == 8'(i)) begin
                if (key_up == target_char(level_q, i)) correct_d[i] = 1'b1;
                else                                   wrong_d[i]   = 1'b1;
              end
            end
            letter_d  = key_up;
            counter_d = counter_q + 8'd1;
            if (counter_q == 8'(WORD_LEN - 1)) state_d = S_CHECK;
          end
`ifdef LEVEL_SEQ_BACKSPACE_EN
          else if (bus.key_ascii == KEY_BACKSPACE && counter_q != 8'd0) begin
            for (int i = 0; i < WORD_LEN; i++) begin
              if (counter_q == 8'(i + 1)) begin
                correct_d[i] = 1'b0;
                wrong_d[i]   = 1'b0;
              end
            end
            counter_d = counter_q - 8'd1;
            letter_d  = ASCII_SPACE;
          end
`endif
        end
      end
      S_CHECK: begin
        timer_start = 1'b1;
        state_d     = (&correct_q) ? S_WON : S_LOST;
      end
      S_WON: begin
        if (timer_expired) begin
          if (level_q == 3'(NUM_LEVELS - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_PLAY;
            level_d   = level_q + 3'd1;
            counter_d = '0;
            correct_d = '0;
            wrong_d   = '0;
          end
        end
      end
      S_LOST: begin
        if (timer_expired) begin
          state_d   = S_PLAY;
          counter_d = '0;
          correct_d = '0;
          wrong_d   = '0;
        end
      end
      S_DONE: begin
        if (key_enter) begin
          state_d = S_IDLE;
          level_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    won_d  = (state_d == S_WON);
    lost_d = (state_d == S_LOST);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      counter_q <= '0;
      letter_q  <= ASCII_SPACE;
      correct_q <= '0;
      wrong_q   <= '0;
      level_q   <= '0;
      won_q     <= 1'b0;
      lost_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      letter_q  <= letter_d;
      correct_q <= correct_d;
      wrong_q   <= wrong_d;
      level_q   <= level_d;
      won_q     <= won_d;
      lost_q    <= lost_d;
      done_q    <= done_d;
    end
  end

  assign bus.counter      = counter_q;
  assign bus.letter       = letter_q;
  assign bus.correct_mask = correct_q;
  assign bus.wrong_mask   = wrong_q;
  assign bus.level        = level_q;
  assign bus.state_out    = state_q;
  assign bus.lvl_won      = won_q;
  assign bus.lvl_lost     = lost_q;
  assign bus.game_done    = done_q;
endmodule

// File: tb/tb_level_sequencer.sv
// Directed plus randomized bench for level_sequencer; expected status comes
// from a word-level model (target strings, per-attempt masks, level count).
module tb_level_sequencer;
  import level_pkg::*;

  localparam int WL   = 5;
  localparam int NL   = 3;
  localparam int HOLD = 4;

  typedef logic [7:0] word_t [WL];

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  level_sequencer_if #(.WORD_LEN(WL)) bus ();

  level_sequencer #(.NUM_LEVELS(NL), .WORD_LEN(WL), .WIN_HOLD(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  string words [NL] = '{"LOGIC", "CLOCK", "ADDER"};
  int          m_level;
  int          m_cnt;
  logic [7:0]  m_letter;
  logic [WL-1:0] m_cor, m_wrong;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] k);
    bus.key_valid = 1'b1;
    bus.key_ascii = k;
    tick();
    bus.key_valid = 1'b0;
    bus.key_ascii = 8'h00;
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".counter"}, bus.counter, m_cnt);
    chk({tag, ".letter"},  bus.letter, m_letter);
    chk({tag, ".correct"}, bus.correct_mask, m_cor);
    chk({tag, ".wrong"},   bus.wrong_mask, m_wrong);
    chk({tag, ".level"},   bus.level, m_level);
  endtask

  task automatic check_reset(input string tag);
    m_level = 0; m_cnt = 0; m_letter = 8'h20; m_cor = '0; m_wrong = '0;
    check_status(tag);
    chk({tag, ".state"}, bus.state_out, S_IDLE);
    chk({tag, ".won"},   bus.lvl_won, 0);
    chk({tag, ".lost"},  bus.lvl_lost, 0);
    chk({tag, ".done"},  bus.game_done, 0);
  endtask

  function automatic word_t mk(input string s);
    word_t w;
    for (int i = 0; i < WL; i++) w[i] = s[i];
    return w;
  endfunction

  // Type one word (uppercase input), random case, optional digit junk between letters.
  task automatic type_word(input word_t w, input bit junk);
    logic [7:0] up;
    for (int i = 0; i < WL; i++) begin
      if (junk && $urandom_range(2) == 0) begin
        press(8'h30 + 8'($urandom_range(9)));
        check_status("junk");
      end
      up = w[i];
      press(($urandom_range(1) == 1) ? up + 8'h20 : up);
      m_letter = up;
      if (up == words[m_level][i]) m_cor[i] = 1'b1;
      else                         m_wrong[i] = 1'b1;
      m_cnt++;
      check_status("letter");
    end
    chk("check_state", bus.state_out, S_CHECK);
  endtask

  task automatic hold_and_advance();
    bit win;
    int n;
    win = (m_cor == '1);
    tick();
    chk("won_flag",  bus.lvl_won, win);
    chk("lost_flag", bus.lvl_lost, !win);
    n = 0;
    while ((bus.lvl_won || bus.lvl_lost) && n < 3 * HOLD) begin
      if (n == 0) press(8'h4C);
      else        tick();
      n++;
      if (n < HOLD) check_status("hold_drop");
    end
    chk("hold_len", n, HOLD);
    m_cnt = 0; m_cor = '0; m_wrong = '0;
    if (win && m_level == NL - 1) begin
      chk("done_state", bus.state_out, S_DONE);
      chk("game_done",  bus.game_done, 1);
    end else begin
      if (win) m_level++;
      chk("play_state", bus.state_out, S_PLAY);
      check_status("advance");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    word_t w;
    int guard;
    bus.key_valid = 1'b0;
    bus.key_ascii = 8'h00;
    reset = 1'b1;
    tick();
    tick();
    check_reset("reset");
    reset = 1'b0;

    press(8'h4C);
    check_reset("idle_ignore");
    press(KEY_ENTER);
    chk("enter_play", bus.state_out, S_PLAY);

    type_word(mk("LOGIX"), 1'b0);
    chk("logix.correct", bus.correct_mask, 5'b01111);
    chk("logix.wrong",   bus.wrong_mask, 5'b10000);
    hold_and_advance();
    chk("logix.level", bus.level, 0);

    type_word(mk("LOGIC"), 1'b0);
    chk("logic.correct", bus.correct_mask, 5'b11111);
    hold_and_advance();
    chk("logic.level", bus.level, 1);

    press(8'h37);
    chk("digit.counter", bus.counter, 0);

    for (int a = 0; a < 8 && !bus.game_done; a++) begin
      for (int i = 0; i < WL; i++) begin
        if ($urandom_range(1) == 1) w[i] = words[m_level][i];
        else                        w[i] = 8'h41 + 8'($urandom_range(25));
      end
      type_word(w, 1'b1);
      hold_and_advance();
    end
    guard = 0;
    while (!bus.game_done && guard < NL) begin
      type_word(mk(words[m_level]), 1'b1);
      hold_and_advance();
      guard++;
    end
    chk("final_done", bus.game_done, 1);

    press(8'h41);
    chk("done_ignore", bus.state_out, S_DONE);
    press(KEY_ENTER);
    chk("done_to_idle", bus.state_out, S_IDLE);
    chk("done_level0",  bus.level, 0);
    m_level = 0;

    press(KEY_ENTER);
    press(8'h4C);
    press(8'h4F);
    press(8'h47);
    chk("pre_reset.counter", bus.counter, 3);
    reset = 1'b1;
    bus.key_valid = 1'b1;
    bus.key_ascii = 8'h49;
    tick();
    reset = 1'b0;
    bus.key_valid = 1'b0;
    check_reset("mid_reset");

    press(KEY_ENTER);
    press(8'h4C);
`ifdef LEVEL_SEQ_BACKSPACE_EN
    press(8'h58);
    press(KEY_BACKSPACE);
    chk("bs.counter1", bus.counter, 1);
    chk("bs.letter",   bus.letter, 8'h20);
    press(8'h4F);
    chk("bs.counter",  bus.counter, 2);
    chk("bs.correct",  bus.correct_mask, 5'b00011);
    chk("bs.wrong",    bus.wrong_mask, 5'b00000);
    press(KEY_BACKSPACE);
    press(KEY_BACKSPACE);
    press(KEY_BACKSPACE);
    chk("bs.zero",     bus.counter, 0);
    chk("bs.zero_mask", bus.correct_mask, 5'b00000);
`else
    press(KEY_BACKSPACE);
    chk("nobs.counter", bus.counter, 1);
    chk("nobs.letter",  bus.letter, 8'h4C);
    chk("nobs.correct", bus.correct_mask, 5'b00001);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
